// File: rtl/cmac_seq_pkg.sv
// Shared definitions for the CMAC link sequencer: per-port state codes,
// the counter-width helper and a saturating 8-bit increment used by the
// retry and drop statistics.
package cmac_seq_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_ALIGN = 3'd1,
    ST_STABLE     = 3'd2,
    ST_UP         = 3'd3,
    ST_RESYNC     = 3'd4
  } seq_state_t;

  // Bits needed to hold values 0..max_val; never less than one bit.
  function automatic int cnt_width(input int unsigned max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

  // Statistics counters stick at all-ones rather than wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/cmac_link_seq_if.sv
// Bundle between the link sequencer and its environment: per-port enables
// and alignment status in, CMAC control levels, status and counters out.
// The master side drives port_en/rx_aligned; the slave side is the sequencer.
interface cmac_link_seq_if
  import cmac_seq_pkg::*;
#(
  parameter int N_PORTS = 2
);
  logic [N_PORTS-1:0]         port_en;
  logic [N_PORTS-1:0]         rx_aligned;
  logic [N_PORTS-1:0]         ctl_rx_enable;
  logic [N_PORTS-1:0]         ctl_tx_enable;
  logic [N_PORTS-1:0]         ctl_tx_send_lfi;
  logic [N_PORTS-1:0]         ctl_tx_send_rfi;
  logic [N_PORTS-1:0]         ctl_rx_force_resync;
  logic [N_PORTS-1:0]         link_up;
  logic [8*N_PORTS-1:0]       retry_cnt;
  logic [8*N_PORTS-1:0]       drop_cnt;
  logic [STATE_W*N_PORTS-1:0] state_o;

  modport master (
    output port_en, rx_aligned,
    input  ctl_rx_enable, ctl_tx_enable, ctl_tx_send_lfi, ctl_tx_send_rfi,
    input  ctl_rx_force_resync, link_up, retry_cnt, drop_cnt, state_o
  );

  modport slave (
    input  port_en, rx_aligned,
    output ctl_rx_enable, ctl_tx_enable, ctl_tx_send_lfi, ctl_tx_send_rfi,
    output ctl_rx_force_resync, link_up, retry_cnt, drop_cnt, state_o
  );
endinterface

// File: rtl/cmac_link_seq_port.sv
// Single-port CMAC bring-up FSM: IDLE -> WAIT_ALIGN -> STABLE -> UP, timed RESYNC on no alignment.
// Latency: state moves one clk after the qualifying input; outputs decode the state register only.
// No backpressure: level inputs are sampled every cycle, outputs are static control levels.
module cmac_link_seq_port
  import cmac_seq_pkg::*;
#(
  parameter int STABLE_CYCLES = 16,
  parameter int ALIGN_TIMEOUT = 200000,
  parameter int RESYNC_PULSE  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               port_en,
  input  logic               rx_aligned,
  output logic               ctl_rx_enable,
  output logic               ctl_tx_enable,
  output logic               ctl_tx_send_lfi,
  output logic               ctl_tx_send_rfi,
  output logic               ctl_rx_force_resync,
  output logic               link_up,
  output logic [7:0]         retry_cnt,
  output logic [7:0]         drop_cnt,
  output logic [STATE_W-1:0] state_o
);

  localparam int TO_W = cnt_width(ALIGN_TIMEOUT);
  localparam int ST_W = cnt_width(STABLE_CYCLES);
  localparam int RS_W = cnt_width(RESYNC_PULSE);

  // Terminal values: the cycle on which each phase ends.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ALIGN_TIMEOUT - 1);
  localparam logic [ST_W-1:0] ST_LAST = ST_W'(STABLE_CYCLES - 1);
  localparam logic [RS_W-1:0] RS_LAST = RS_W'(RESYNC_PULSE - 1);

  seq_state_t      state_q, state_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [ST_W-1:0] st_cnt_q, st_cnt_d;
  logic [RS_W-1:0] rs_cnt_q, rs_cnt_d;
  logic [7:0]      retry_q, retry_d;
  logic [7:0]      drop_q, drop_d;

  // State and counter registers; reset clears statistics as well.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      to_cnt_q <= '0;
      st_cnt_q <= '0;
      rs_cnt_q <= '0;
      retry_q  <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
      st_cnt_q <= st_cnt_d;
      rs_cnt_q <= rs_cnt_d;
      retry_q  <= retry_d;
      drop_q   <= drop_d;
    end
  end

  // Next state; phase counters fall to zero whenever their phase is left,
  // so every entry into WAIT_ALIGN or RESYNC starts from a clean count.
  always_comb begin
    state_d  = state_q;
    to_cnt_d = '0;
    st_cnt_d = '0;
    rs_cnt_d = '0;
    retry_d  = retry_q;
    drop_d   = drop_q;
    if (!port_en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_WAIT_ALIGN;
        ST_WAIT_ALIGN: begin
          if (rx_aligned) begin
            state_d  = ST_STABLE;
            st_cnt_d = ST_W'(1);
          end else if (to_cnt_q == TO_LAST) begin
            state_d = ST_RESYNC;
            retry_d = sat_inc8(retry_q);
          end else begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
        end
        ST_STABLE: begin
          if (!rx_aligned) begin
            state_d = ST_WAIT_ALIGN;
          end else if (st_cnt_q >= ST_LAST) begin
            state_d = ST_UP;
          end else begin
            st_cnt_d = st_cnt_q + 1'b1;
          end
        end
        ST_UP: begin
          if (!rx_aligned) begin
            state_d = ST_WAIT_ALIGN;
            drop_d  = sat_inc8(drop_q);
          end
        end
        ST_RESYNC: begin
          if (rs_cnt_q == RS_LAST) begin
            state_d = ST_WAIT_ALIGN;
          end else begin
            rs_cnt_d = rs_cnt_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Moore decode of the control levels from the registered state.
  always_comb begin
    ctl_rx_enable       = 1'b0;
    ctl_tx_enable       = 1'b0;
    ctl_tx_send_lfi     = 1'b0;
    ctl_tx_send_rfi     = 1'b0;
    ctl_rx_force_resync = 1'b0;
    link_up             = 1'b0;
    case (state_q)
      ST_WAIT_ALIGN, ST_STABLE: begin
        ctl_rx_enable   = 1'b1;
        ctl_tx_send_lfi = 1'b1;
        ctl_tx_send_rfi = 1'b1;
      end
      ST_UP: begin
        ctl_rx_enable = 1'b1;
        ctl_tx_enable = 1'b1;
        link_up       = 1'b1;
      end
      ST_RESYNC: begin
        ctl_rx_enable       = 1'b1;
        ctl_tx_send_lfi     = 1'b1;
        ctl_tx_send_rfi     = 1'b1;
        ctl_rx_force_resync = 1'b1;
      end
      default: ;
    endcase
  end

  assign retry_cnt = retry_q;
  assign drop_cnt  = drop_q;
  assign state_o   = state_q;

endmodule

// File: rtl/cmac_link_seq.sv
// Multi-port CMAC link sequencer: one independent bring-up FSM per port.
// Latency: each port reacts one clk after its inputs; outputs come from registered state.
// No backpressure: ports never stall each other and inputs are sampled every cycle.
module cmac_link_seq
  import cmac_seq_pkg::*;
#(
  parameter int N_PORTS       = 2,
  parameter int STABLE_CYCLES = 16,
  parameter int ALIGN_TIMEOUT = 200000,
  parameter int RESYNC_PULSE  = 4
) (
  input logic            clk,
  input logic            rst,
  cmac_link_seq_if.slave lnk
);

  for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_port
    cmac_link_seq_port #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .ALIGN_TIMEOUT (ALIGN_TIMEOUT),
      .RESYNC_PULSE  (RESYNC_PULSE)
    ) u_port (
      .clk                 (clk),
      .rst                 (rst),
      .port_en             (lnk.port_en[gi]),
      .rx_aligned          (lnk.rx_aligned[gi]),
      .ctl_rx_enable       (lnk.ctl_rx_enable[gi]),
      .ctl_tx_enable       (lnk.ctl_tx_enable[gi]),
      .ctl_tx_send_lfi     (lnk.ctl_tx_send_lfi[gi]),
      .ctl_tx_send_rfi     (lnk.ctl_tx_send_rfi[gi]),
      .ctl_rx_force_resync (lnk.ctl_rx_force_resync[gi]),
      .link_up             (lnk.link_up[gi]),
      .retry_cnt           (lnk.retry_cnt[8*gi +: 8]),
      .drop_cnt            (lnk.drop_cnt[8*gi +: 8]),
      .state_o             (lnk.state_o[STATE_W*gi +: STATE_W])
    );
  end

endmodule

// File: tb/tb_cmac_link_seq.sv
// Bench for cmac_link_seq: directed scenarios plus random stimulus, every
// cycle compared against a phase-level model of the bring-up rules.
module tb_cmac_link_seq;

  localparam int NP = 2;
  localparam int SC = 4;
  localparam int AT = 20;
  localparam int RP = 3;

  localparam int M_IDLE = 0, M_WAIT = 1, M_STABLE = 2, M_UP = 3, M_RESYNC = 4;

  logic clk = 1'b0;
  logic rst;

  cmac_link_seq_if #(.N_PORTS(NP)) lnk ();

  cmac_link_seq #(
    .N_PORTS(NP), .STABLE_CYCLES(SC), .ALIGN_TIMEOUT(AT), .RESYNC_PULSE(RP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .lnk (lnk)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: current phase, cycles spent hunting for alignment, length of the
  // current run of aligned samples, remaining resync pulse, statistics.
  int m_mode[NP], m_waited[NP], m_run[NP], m_pulse[NP], m_retry[NP], m_drop[NP];

  task automatic model_step();
    for (int p = 0; p < NP; p++) begin
      if (rst) begin
        m_mode[p] = M_IDLE; m_waited[p] = 0; m_run[p] = 0;
        m_pulse[p] = 0; m_retry[p] = 0; m_drop[p] = 0;
      end else if (!lnk.port_en[p]) begin
        m_mode[p] = M_IDLE; m_waited[p] = 0; m_run[p] = 0;
      end else begin
        case (m_mode[p])
          M_IDLE: begin m_mode[p] = M_WAIT; m_waited[p] = 0; end
          M_WAIT: begin
            if (lnk.rx_aligned[p]) begin
              m_mode[p] = M_STABLE; m_run[p] = 1;
            end else begin
              m_waited[p]++;
              if (m_waited[p] == AT) begin
                m_mode[p] = M_RESYNC; m_pulse[p] = RP;
                if (m_retry[p] < 255) m_retry[p]++;
              end
            end
          end
          M_STABLE: begin
            if (!lnk.rx_aligned[p]) begin
              m_mode[p] = M_WAIT; m_waited[p] = 0;
            end else begin
              m_run[p]++;
              if (m_run[p] >= SC) m_mode[p] = M_UP;
            end
          end
          M_UP: begin
            if (!lnk.rx_aligned[p]) begin
              m_mode[p] = M_WAIT; m_waited[p] = 0;
              if (m_drop[p] < 255) m_drop[p]++;
            end
          end
          default: begin
            m_pulse[p]--;
            if (m_pulse[p] == 0) begin m_mode[p] = M_WAIT; m_waited[p] = 0; end
          end
        endcase
      end
    end
  endtask

  // {state, rx_en, tx_en, lfi, rfi, resync, link_up, retry, drop}
  function automatic logic [24:0] exp_bundle(int p);
    logic rxe, txe, flt, rsy;
    rxe = (m_mode[p] != M_IDLE);
    txe = (m_mode[p] == M_UP);
    flt = (m_mode[p] == M_WAIT) || (m_mode[p] == M_STABLE) || (m_mode[p] == M_RESYNC);
    rsy = (m_mode[p] == M_RESYNC);
    return {3'(m_mode[p]), rxe, txe, flt, flt, rsy, txe, 8'(m_retry[p]), 8'(m_drop[p])};
  endfunction

  function automatic logic [24:0] obs_bundle(int p);
    return {lnk.state_o[3*p +: 3], lnk.ctl_rx_enable[p], lnk.ctl_tx_enable[p],
            lnk.ctl_tx_send_lfi[p], lnk.ctl_tx_send_rfi[p], lnk.ctl_rx_force_resync[p],
            lnk.link_up[p], lnk.retry_cnt[8*p +: 8], lnk.drop_cnt[8*p +: 8]};
  endfunction

  // Advance one clock; model consumes the inputs present at the edge,
  // DUT outputs are then stable 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; lnk.port_en = '0; lnk.rx_aligned = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; lnk.port_en = 2'b11; lnk.rx_aligned = 2'($urandom);
    tick(); tick();
    for (int p = 0; p < NP; p++) begin
      vectors++;
      if (obs_bundle(p) !== 25'h0) begin
        miscompares++;
        $display("FAIL reset_zero port%0d: got %h want 0", p, obs_bundle(p));
      end
    end
    rst = 1'b0; lnk.port_en = 2'b01;
    vectors++;
    if (lnk.state_o[2:0] !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_release_idle: got state %0d want 0", lnk.state_o[2:0]);
    end
    tick();
    vectors++;
    if (lnk.state_o !== 6'b000_001) begin
      miscompares++;
      $display("FAIL reset_release_wait: got state_o %b want 000001", lnk.state_o);
    end
    for (int p = 0; p < NP; p++) begin
      vectors++;
      if (obs_bundle(p) !== exp_bundle(p)) begin
        miscompares++;
        $display("FAIL reset_lockstep port%0d @%0t: got %h want %h", p, $time, obs_bundle(p), exp_bundle(p));
      end
    end
  endtask

  task automatic test_align();
    int up_at;
    do_reset();
    lnk.port_en = 2'b01; lnk.rx_aligned = 2'b00;
    tick();
    vectors++;
    if (lnk.state_o[2:0] !== 3'd1) begin
      miscompares++;
      $display("FAIL align_wait_entry: got state %0d want 1", lnk.state_o[2:0]);
    end
    repeat (5) tick();
    lnk.rx_aligned = 2'b01;
    up_at = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      for (int p = 0; p < NP; p++) begin
        vectors++;
        if (obs_bundle(p) !== exp_bundle(p)) begin
          miscompares++;
          $display("FAIL align_lockstep port%0d @%0t: got %h want %h", p, $time, obs_bundle(p), exp_bundle(p));
        end
      end
      if (up_at == 0 && lnk.ctl_tx_enable[0] && lnk.link_up[0]) up_at = k;
      else if (up_at == 0) begin
        vectors++;
        if ({lnk.ctl_tx_send_lfi[0], lnk.ctl_tx_send_rfi[0]} !== 2'b11) begin
          miscompares++;
          $display("FAIL align_fault_ind k=%0d: got lfi/rfi %b want 11", k, {lnk.ctl_tx_send_lfi[0], lnk.ctl_tx_send_rfi[0]});
        end
      end
    end
    vectors++;
    if (up_at != SC) begin
      miscompares++;
      $display("FAIL align_up_latency: got %0d cycles want %0d", up_at, SC);
    end
  endtask

  task automatic test_timeout();
    int n_wait, n_rs;
    do_reset();
    lnk.port_en = 2'b01; lnk.rx_aligned = 2'b00;
    tick();
    n_wait = 0;
    while (lnk.state_o[2:0] == 3'd1 && n_wait < 100) begin
      n_wait++;
      tick();
    end
    vectors++;
    if (n_wait != AT || lnk.state_o[2:0] !== 3'd4) begin
      miscompares++;
      $display("FAIL timeout_wait_len: got %0d cycles then state %0d want %0d then 4", n_wait, lnk.state_o[2:0], AT);
    end
    n_rs = 0;
    while (lnk.ctl_rx_force_resync[0] && n_rs < 50) begin
      n_rs++;
      tick();
    end
    vectors++;
    if (n_rs != RP) begin
      miscompares++;
      $display("FAIL timeout_pulse_len: got %0d want %0d", n_rs, RP);
    end
    vectors++;
    if (lnk.retry_cnt[7:0] !== 8'd1) begin
      miscompares++;
      $display("FAIL timeout_retry_one: got %0d want 1", lnk.retry_cnt[7:0]);
    end
    repeat (300 * (AT + RP)) begin
      tick();
      for (int p = 0; p < NP; p++) begin
        vectors++;
        if (obs_bundle(p) !== exp_bundle(p)) begin
          miscompares++;
          $display("FAIL timeout_lockstep port%0d @%0t: got %h want %h", p, $time, obs_bundle(p), exp_bundle(p));
        end
      end
    end
    vectors++;
    if (lnk.retry_cnt[7:0] !== 8'd255) begin
      miscompares++;
      $display("FAIL timeout_retry_sat: got %0d want 255", lnk.retry_cnt[7:0]);
    end
    repeat (2 * (AT + RP)) tick();
    vectors++;
    if (lnk.retry_cnt[7:0] !== 8'd255) begin
      miscompares++;
      $display("FAIL timeout_retry_hold: got %0d want 255", lnk.retry_cnt[7:0]);
    end
  endtask

  task automatic test_glitch();
    int up_at;
    do_reset();
    lnk.port_en = 2'b01; lnk.rx_aligned = 2'b00;
    tick();
    lnk.rx_aligned = 2'b01;
    tick(); tick();
    vectors++;
    if (lnk.state_o[2:0] !== 3'd2) begin
      miscompares++;
      $display("FAIL glitch_in_stable: got state %0d want 2", lnk.state_o[2:0]);
    end
    lnk.rx_aligned = 2'b00;
    tick();
    vectors++;
    if (lnk.state_o[2:0] !== 3'd1 || lnk.ctl_tx_enable[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL glitch_back_to_wait: got state %0d tx %b want 1 0", lnk.state_o[2:0], lnk.ctl_tx_enable[0]);
    end
    lnk.rx_aligned = 2'b01;
    up_at = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      for (int p = 0; p < NP; p++) begin
        vectors++;
        if (obs_bundle(p) !== exp_bundle(p)) begin
          miscompares++;
          $display("FAIL glitch_lockstep port%0d @%0t: got %h want %h", p, $time, obs_bundle(p), exp_bundle(p));
        end
      end
      if (up_at == 0 && lnk.link_up[0]) up_at = k;
    end
    vectors++;
    if (up_at != SC) begin
      miscompares++;
      $display("FAIL glitch_fresh_run: got UP after %0d cycles want %0d", up_at, SC);
    end
  endtask

  task automatic test_drop();
    logic [24:0] p1_up;
    p1_up = {3'd3, 6'b110001, 16'h0000};
    do_reset();
    lnk.port_en = 2'b11; lnk.rx_aligned = 2'b11;
    repeat (6) tick();
    vectors++;
    if (lnk.link_up !== 2'b11) begin
      miscompares++;
      $display("FAIL drop_both_up: got link_up %b want 11", lnk.link_up);
    end
    lnk.rx_aligned = 2'b10;
    tick();
    vectors++;
    if ({lnk.state_o[2:0], lnk.ctl_tx_enable[0], lnk.ctl_tx_send_lfi[0], lnk.drop_cnt[7:0]} !== {3'd1, 1'b0, 1'b1, 8'd1}) begin
      miscompares++;
      $display("FAIL drop_port0: got state %0d tx %b lfi %b drop %0d want 1 0 1 1",
               lnk.state_o[2:0], lnk.ctl_tx_enable[0], lnk.ctl_tx_send_lfi[0], lnk.drop_cnt[7:0]);
    end
    for (int k = 0; k < 40; k++) begin
      vectors++;
      if (obs_bundle(1) !== p1_up) begin
        miscompares++;
        $display("FAIL drop_port1_isolated k=%0d: got %h want %h", k, obs_bundle(1), p1_up);
      end
      lnk.port_en[0] = ($urandom_range(0, 9) != 0);
      lnk.rx_aligned[0] = 1'($urandom);
      tick();
      vectors++;
      if (obs_bundle(0) !== exp_bundle(0)) begin
        miscompares++;
        $display("FAIL drop_lockstep port0 @%0t: got %h want %h", $time, obs_bundle(0), exp_bundle(0));
      end
    end
  endtask

  task automatic test_abort();
    int guard;
    do_reset();
    lnk.port_en = 2'b01; lnk.rx_aligned = 2'b00;
    tick();
    repeat (AT + 1) tick();
    vectors++;
    if (lnk.state_o[2:0] !== 3'd4) begin
      miscompares++;
      $display("FAIL abort_in_resync: got state %0d want 4", lnk.state_o[2:0]);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (obs_bundle(0) !== 25'h0) begin
      miscompares++;
      $display("FAIL abort_rst_mid_resync: got %h want 0", obs_bundle(0));
    end
    // Build up one retry and one drop, then end in UP.
    tick();
    guard = 0;
    while (lnk.state_o[2:0] != 3'd4 && guard < 60) begin guard++; tick(); end
    while (lnk.state_o[2:0] != 3'd1 && guard < 60) begin guard++; tick(); end
    lnk.rx_aligned = 2'b01;
    while (!lnk.link_up[0] && guard < 60) begin guard++; tick(); end
    lnk.rx_aligned = 2'b00;
    tick();
    lnk.rx_aligned = 2'b01;
    while (!lnk.link_up[0] && guard < 60) begin guard++; tick(); end
    vectors++;
    if (guard >= 60 || obs_bundle(0) !== exp_bundle(0)) begin
      miscompares++;
      $display("FAIL abort_reach_up: guard %0d got %h want %h", guard, obs_bundle(0), exp_bundle(0));
    end
    lnk.port_en = 2'b00;
    tick();
    vectors++;
    if (obs_bundle(0) !== {3'd0, 6'b000000, 8'd1, 8'd1}) begin
      miscompares++;
      $display("FAIL abort_disable_in_up: got %h want %h", obs_bundle(0), {3'd0, 6'b000000, 8'd1, 8'd1});
    end
    repeat (5) begin lnk.rx_aligned = 2'($urandom); tick(); end
    vectors++;
    if ({lnk.retry_cnt[7:0], lnk.drop_cnt[7:0]} !== {8'd1, 8'd1}) begin
      miscompares++;
      $display("FAIL abort_counters_hold: got retry %0d drop %0d want 1 1", lnk.retry_cnt[7:0], lnk.drop_cnt[7:0]);
    end
  endtask

  task automatic test_random();
    int regime[NP];
    logic [NP-1:0] en, al;
    for (int p = 0; p < NP; p++) regime[p] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(0, 39) == 0) regime[p] = $urandom_range(0, 2);
        en[p] = ($urandom_range(0, 99) != 0);
        case (regime[p])
          0:       al[p] = ($urandom_range(0, 49) != 0);
          1:       al[p] = ($urandom_range(0, 49) == 0);
          default: al[p] = 1'($urandom);
        endcase
      end
      rst = ($urandom_range(0, 499) == 0);
      lnk.port_en = en; lnk.rx_aligned = al;
      tick();
      for (int p = 0; p < NP; p++) begin
        vectors++;
        if (obs_bundle(p) !== exp_bundle(p)) begin
          miscompares++;
          $display("FAIL random_lockstep port%0d @%0t: got %h want %h", p, $time, obs_bundle(p), exp_bundle(p));
        end
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    lnk.port_en = '0;
    lnk.rx_aligned = '0;
    test_reset();
    test_align();
    test_timeout();
    test_glitch();
    test_drop();
    test_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cmac_link_seq.md
CMAC_LINK_SEQ -- requirements
Module: cmac_link_seq

Interface
REQ-001 Parameter N_PORTS, default 2: number of independent CMAC ports sequenced.
REQ-002 Parameter STABLE_CYCLES, default 16: consecutive rx_aligned cycles required before TX enable.
REQ-003 Parameter ALIGN_TIMEOUT, default 200000: cycles waited for alignment before forced resync.
REQ-004 Parameter RESYNC_PULSE, default 4: ctl_rx_force_resync pulse length in cycles.
REQ-005 Clock clk; reset rst, synchronous, active-high.
REQ-006 clk  input  1  sequencer clock, shared by all ports.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 port_en  input  N_PORTS  per-port enable; low forces that port to IDLE.
REQ-009 rx_aligned  input  N_PORTS  per-port CMAC RX alignment status, already synchronous to clk.
REQ-010 ctl_rx_enable  output  N_PORTS  CMAC RX enable.
REQ-011 ctl_tx_enable  output  N_PORTS  CMAC TX enable.
REQ-012 ctl_tx_send_lfi  output  N_PORTS  send local fault indication.
REQ-013 ctl_tx_send_rfi  output  N_PORTS  send remote fault indication.
REQ-014 ctl_rx_force_resync  output  N_PORTS  force RX resync.
REQ-015 link_up  output  N_PORTS  port in UP state.
REQ-016 retry_cnt  output  8*N_PORTS  per-port saturating timeout-resync count, port i at bits [8i+7:8i].
REQ-017 drop_cnt  output  8*N_PORTS  per-port saturating link-loss count, same packing.
REQ-018 state_o  output  3*N_PORTS  per-port state encoding, for debug.

Function
REQ-019 Each port SHALL run an independent FSM: IDLE, WAIT_ALIGN, STABLE, UP, RESYNC.
REQ-020 All outputs SHALL be Moore-decoded from registered state; there SHALL be no combinational path from inputs to outputs.
REQ-021 IDLE: all ctl outputs 0; port_en=1 -> WAIT_ALIGN next cycle.
REQ-022 WAIT_ALIGN: rx_enable=1, lfi=1, rfi=1, tx_enable=0; timeout counter increments each cycle.
REQ-023 In WAIT_ALIGN, rx_aligned=1 -> STABLE, with the stable counter loaded to 1.
REQ-024 In WAIT_ALIGN, timeout counter = ALIGN_TIMEOUT-1 with rx_aligned=0 -> RESYNC; rx_aligned=1 in the same cycle takes priority (-> STABLE).
REQ-025 STABLE: outputs as WAIT_ALIGN; stable counter increments while rx_aligned=1; on reaching STABLE_CYCLES -> UP.
REQ-026 In STABLE, rx_aligned=0 -> WAIT_ALIGN, with the timeout counter cleared.
REQ-027 UP: rx_enable=1, tx_enable=1, lfi=0, rfi=0, link_up=1.
REQ-028 In UP, rx_aligned=0 -> WAIT_ALIGN; drop_cnt increments, saturating at 255.
REQ-029 RESYNC: force_resync=1, rx_enable=1, lfi=rfi=1, tx_enable=0, for exactly RESYNC_PULSE cycles, then -> WAIT_ALIGN with the timeout counter cleared.
REQ-030 Entry to RESYNC SHALL increment retry_cnt, saturating at 255.
REQ-031 port_en=0 in any state -> IDLE next cycle, overriding all other transitions; the timeout and stable counters clear; retry_cnt and drop_cnt hold.
REQ-032 Timeout counter width SHALL be clog2(ALIGN_TIMEOUT+1); stable counter width SHALL be clog2(STABLE_CYCLES+1).
REQ-033 STABLE_CYCLES=1 SHALL give WAIT_ALIGN -> STABLE -> UP in consecutive cycles.

Reset
REQ-034 rst=1: all ports IDLE, all outputs and counters 0 on the next edge; reset asserted mid-sequence (including mid-RESYNC) SHALL abort the sequence immediately.
REQ-035 After rst deasserts, a port with port_en=1 SHALL reach WAIT_ALIGN two cycles later (IDLE, then WAIT_ALIGN).

Structure
REQ-036 Package cmac_seq_pkg SHALL hold the state encodings (IDLE=0, WAIT_ALIGN=1, STABLE=2, UP=3, RESYNC=4) and the counter-width helper function.
REQ-037 Sub-module cmac_link_seq_port SHALL implement one port, instantiated N_PORTS times by generate.

Verification (N_PORTS=2, STABLE_CYCLES=4, ALIGN_TIMEOUT=20, RESYNC_PULSE=3)
REQ-038 Port0 en=1, rx_aligned rises 5 cycles after WAIT_ALIGN entry -> lfi=rfi=1 until UP; tx_enable=1 and link_up=1 exactly 4 cycles after rise.
REQ-039 rx_aligned held 0 -> RESYNC after 20 WAIT_ALIGN cycles; force_resync high 3 cycles; retry_cnt=1; loop 300 times -> retry_cnt=255 held.
REQ-040 rx_aligned glitches low for 1 cycle in STABLE -> WAIT_ALIGN; UP reached only after 4 fresh consecutive aligned cycles.
REQ-041 Port0 in UP, rx_aligned drops -> tx_enable=0, lfi=1 next cycle, drop_cnt=1; port1 outputs unaffected throughout.
REQ-042 rst pulsed during RESYNC, and port_en deasserted in UP -> all port outputs 0 next cycle; after port_en deassert, counters hold.
